// File: rtl/eth_tx_pkg.sv
// Shared types and helpers for the Ethernet TX streaming source.
// Holds the FSM encoding plus beat-count and last-beat keep helpers.
package eth_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int MAX_KEEP = 128;

    function automatic logic [31:0] beat_count(
        input logic [31:0] len,
        input int          kw
    );
        logic [31:0] k;
        k = 32'(kw);
        return (len + k - 32'd1) / k;
    endfunction

    // Low (len mod kw) bits set; a full word when the remainder is zero.
    function automatic logic [MAX_KEEP-1:0] keep_from_rem(
        input logic [31:0] len,
        input int          kw
    );
        logic [MAX_KEEP-1:0] m;
        logic [31:0]         k;
        logic [31:0]         rem;
        k   = 32'(kw);
        rem = len % k;
        m   = '0;
        for (int i = 0; i < MAX_KEEP; i++) begin
            if (rem == 32'd0)
                m[i] = (i < kw);
            else
                m[i] = (32'(i) < rem);
        end
        return m;
    endfunction

endpackage

// File: rtl/eth_tx_axis_source_buf.sv
// Two-entry registered AXI-Stream output buffer with read credit.
// Tracks one in-flight RAM read and only grants reads that will fit.
module axis_out_buf2 #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue,
    input  logic [TAG_WIDTH-1:0]  issue_tag,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  can_issue,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    localparam int W = TAG_WIDTH + DATA_WIDTH;

    logic [W-1:0]         mem0;
    logic [W-1:0]         mem1;
    logic [W-1:0]         wdata;
    logic [1:0]           count;
    logic [1:0]           occ;
    logic                 inflight;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 pop;
    logic                 push;

    assign pop   = out_valid && out_ready;
    assign push  = inflight;
    assign wdata = {tag_q, rd_data};

    // A departing beat frees its slot this cycle, which keeps 1 beat/cycle.
    assign occ       = count + {1'b0, inflight} - {1'b0, pop};
    assign can_issue = (occ < 2'd2);

    assign out_valid           = (count != 2'd0);
    assign {out_tag, out_data} = out_valid ? mem0 : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= 2'd0;
            inflight <= 1'b0;
            tag_q    <= '0;
            mem0     <= '0;
            mem1     <= '0;
        end else begin
            inflight <= issue;
            if (issue)
                tag_q <= issue_tag;
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop)
                mem0 <= mem1;
            if (push) begin
                if (count == 2'd0 || (count == 2'd1 && pop))
                    mem0 <= wdata;
                else
                    mem1 <= wdata;
            end
        end
    end

endmodule

// File: rtl/eth_tx_axis_source.sv
// TX streaming source: reads a frame from the TX buffer RAM and
// emits it as one AXI-Stream packet with tkeep/tlast/tuser.
module eth_tx_axis_source #(
    parameter int DATA_WIDTH     = 32,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int BUF_ADDR_WIDTH = 9,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [BUF_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    input  logic                      cmd_bad,
    output logic                      buf_rd_en,
    output logic [BUF_ADDR_WIDTH-1:0] buf_rd_addr,
    input  logic [DATA_WIDTH-1:0]     buf_rd_data,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]     m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic                      done,
    output logic                      busy
);

    import eth_tx_pkg::*;

    localparam int TAG_W = KEEP_WIDTH + 2;

    state_t                    state_q;
    state_t                    state_d;
    logic [BUF_ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]      beats_q;
    logic [LEN_WIDTH-1:0]      issued_q;
    logic [KEEP_WIDTH-1:0]     keep_last_q;
    logic                      bad_q;
    logic                      accept;
    logic                      can_issue;
    logic                      last_issue;
    logic                      hs_last;
    logic [TAG_W-1:0]          issue_tag;
    logic [TAG_W-1:0]          out_tag;

    assign accept     = cmd_valid && cmd_ready;
    assign last_issue = (issued_q == beats_q - LEN_WIDTH'(1));
    assign issue_tag  = {
        last_issue ? keep_last_q : {KEEP_WIDTH{1'b1}},
        last_issue,
        last_issue && bad_q
    };

    assign buf_rd_en = (state_q == ST_STREAM)
                     && (issued_q < beats_q)
                     && can_issue;
    assign buf_rd_addr = addr_q + BUF_ADDR_WIDTH'(issued_q);

    axis_out_buf2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_W)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (buf_rd_en),
        .issue_tag (issue_tag),
        .rd_data   (buf_rd_data),
        .can_issue (can_issue),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (m_axis_tdata),
        .out_tag   (out_tag)
    );

    assign m_axis_tkeep = out_tag[TAG_W-1:2];
    assign m_axis_tlast = out_tag[1];
    assign m_axis_tuser = out_tag[0];
    assign hs_last = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            beats_q     <= '0;
            issued_q    <= '0;
            keep_last_q <= '0;
            bad_q       <= 1'b0;
        end else if (accept) begin
            addr_q      <= cmd_addr;
            beats_q     <= LEN_WIDTH'(beat_count(32'(cmd_len), KEEP_WIDTH));
            issued_q    <= '0;
            keep_last_q <= KEEP_WIDTH'(keep_from_rem(32'(cmd_len), KEEP_WIDTH));
            bad_q       <= cmd_bad;
        end else if (buf_rd_en) begin
            issued_q <= issued_q + LEN_WIDTH'(1);
        end
    end

    // An empty frame still spends one busy cycle in STREAM before DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_STREAM;
            ST_STREAM: begin
                if (beats_q == '0 || hs_last)
                    state_d = ST_DONE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE:   cmd_ready = 1'b1;
            ST_STREAM: busy      = 1'b1;
            ST_DONE:   done      = 1'b1;
            default:   cmd_ready = 1'b0;
        endcase
    end

endmodule
